// File: rtl/pwm_pkg.sv
// Shared types, constants and width helper for the PWM fade array.
// Config fields are sized for intervals up to 65535 clocks and steps up to 16 bits.
package pwm_pkg;

  localparam int DEFAULT_INTERVAL = 1200;
  localparam int CFG_W            = 16;

  typedef struct packed {
    logic [CFG_W-1:0] target;
    logic [CFG_W-1:0] step;
  } ch_cfg_t;

  function automatic int duty_w(input int interval);
    return $clog2(interval + 1);
  endfunction

endpackage

// File: rtl/pwm_fade_array_if.sv
// Host write port of the PWM fade array: one-cycle strobe with channel, target and step.
interface pwm_fade_array_if
  import pwm_pkg::*;
#(
  parameter int PWM_INTERVAL = DEFAULT_INTERVAL,
  parameter int NUM_CH       = 3,
  parameter int STEP_W       = 8
);
  localparam int DW = duty_w(PWM_INTERVAL);
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic              wr_en;
  logic [CW-1:0]     wr_ch;
  logic [DW-1:0]     wr_target;
  logic [STEP_W-1:0] wr_step;

  modport master (output wr_en, output wr_ch, output wr_target, output wr_step);
  modport slave  (input  wr_en, input  wr_ch, input  wr_target, input  wr_step);

endinterface

// File: rtl/pwm_fade_ch.sv
// One PWM channel: stored target/step, duty that fades toward target once per period,
// and the registered comparator output.
module pwm_fade_ch
  import pwm_pkg::*;
#(
  parameter  int PWM_INTERVAL = DEFAULT_INTERVAL,
  parameter  int STEP_W       = 8,
  localparam int DW           = duty_w(PWM_INTERVAL)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DW-1:0]     cnt,
  input  logic              wrap,
  input  logic              wr_sel,
  input  logic [DW-1:0]     wr_target,
  input  logic [STEP_W-1:0] wr_step,
  output logic              pwm_out,
  output logic              settled
);

  localparam logic [DW-1:0] MAX_DUTY = DW'(PWM_INTERVAL);

  ch_cfg_t          cfg_reg, cfg_next;
  logic [DW-1:0]    duty_reg, duty_next;
  logic [CFG_W:0]   tgt_x, duty_x, step_x, diff;

  // The fade reads cfg_reg, so a write landing on the wrap edge only counts from the next wrap.
  always_comb begin
    tgt_x     = {1'b0, cfg_reg.target};
    duty_x    = (CFG_W+1)'(duty_reg);
    step_x    = {1'b0, cfg_reg.step};
    diff      = (tgt_x >= duty_x) ? (tgt_x - duty_x) : (duty_x - tgt_x);
    duty_next = duty_reg;
    if (wrap) begin
      if (step_x == '0 || diff <= step_x)
        duty_next = DW'(tgt_x);
      else if (tgt_x > duty_x)
        duty_next = DW'(duty_x + step_x);
      else
        duty_next = DW'(duty_x - step_x);
    end

    cfg_next = cfg_reg;
    if (wr_sel) begin
      cfg_next.target = CFG_W'((wr_target > MAX_DUTY) ? MAX_DUTY : wr_target);
      cfg_next.step   = CFG_W'(wr_step);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_reg  <= '0;
      duty_reg <= '0;
      pwm_out  <= 1'b0;
      settled  <= 1'b1;
    end else begin
      cfg_reg  <= cfg_next;
      duty_reg <= duty_next;
      pwm_out  <= (cnt < duty_reg);
      settled  <= (CFG_W'(duty_next) == cfg_next.target);
    end
  end

endmodule

// File: rtl/pwm_fade_array.sv
// Multi-channel PWM with per-channel linear fade; all channels share one period counter
// so duty changes land on period boundaries only.
module pwm_fade_array
  import pwm_pkg::*;
#(
  parameter  int PWM_INTERVAL = DEFAULT_INTERVAL,
  parameter  int NUM_CH       = 3,
  parameter  int STEP_W       = 8,
  localparam int DW           = duty_w(PWM_INTERVAL),
  localparam int CW           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  pwm_fade_array_if.slave    wr,
  output logic [NUM_CH-1:0]  pwm_out,
  output logic [NUM_CH-1:0]  settled,
  output logic               period_start
);

  logic [DW-1:0]     cnt_reg;
  logic              wrap;
  logic [NUM_CH-1:0] wr_sel;

  assign wrap = (cnt_reg == DW'(PWM_INTERVAL - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg      <= '0;
      period_start <= 1'b0;
    end else begin
      cnt_reg      <= wrap ? '0 : cnt_reg + 1'b1;
      period_start <= wrap;
    end
  end

  // Indices at or above NUM_CH match no channel, so such writes fall away.
  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign wr_sel[gi] = wr.wr_en && (wr.wr_ch == CW'(gi));

      pwm_fade_ch #(
        .PWM_INTERVAL (PWM_INTERVAL),
        .STEP_W       (STEP_W)
      ) u_ch (
        .clk       (clk),
        .rst_n     (rst_n),
        .cnt       (cnt_reg),
        .wrap      (wrap),
        .wr_sel    (wr_sel[gi]),
        .wr_target (wr.wr_target),
        .wr_step   (wr.wr_step),
        .pwm_out   (pwm_out[gi]),
        .settled   (settled[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_pwm_fade_array.sv
// Directed bench: PWM_INTERVAL=10, STEP_W=4, one 3-channel and one 1-channel instance.
module tb_pwm_fade_array;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] pwm_out, settled;
  logic       period_start;
  logic [0:0] pwm_out1, settled1;
  logic       period_start1;

  int errors = 0;
  int checks = 0;
  int hi_cnt [3];
  logic [2:0] first_s;
  logic [2:0] set_s;

  always #5 clk = ~clk;

  pwm_fade_array_if #(.PWM_INTERVAL(10), .NUM_CH(3), .STEP_W(4)) wif ();
  pwm_fade_array_if #(.PWM_INTERVAL(10), .NUM_CH(1), .STEP_W(4)) wif1 ();

  pwm_fade_array #(.PWM_INTERVAL(10), .NUM_CH(3), .STEP_W(4)) dut (
    .clk (clk), .rst_n (rst_n), .wr (wif),
    .pwm_out (pwm_out), .settled (settled), .period_start (period_start)
  );

  pwm_fade_array #(.PWM_INTERVAL(10), .NUM_CH(1), .STEP_W(4)) dut1 (
    .clk (clk), .rst_n (rst_n), .wr (wif1),
    .pwm_out (pwm_out1), .settled (settled1), .period_start (period_start1)
  );

  // Waits (bounded) for a period_start cycle, then samples the ten cycles that show cnt 0..9.
  task automatic measure(input string tag);
    int w;
    w = 0;
    while (!period_start && w < 30) begin
      @(negedge clk);
      w++;
    end
    if (!period_start) begin
      checks++; errors++;
      $display("FAIL %s: period_start timeout, got 0 required 1", tag);
    end
    first_s = pwm_out;
    for (int c = 0; c < 3; c++) hi_cnt[c] = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k == 0) set_s = settled;
      for (int c = 0; c < 3; c++) hi_cnt[c] += int'(pwm_out[c]);
    end
    $display("%s: high=%0d/%0d/%0d settled=%b", tag, hi_cnt[0], hi_cnt[1], hi_cnt[2], set_s);
  endtask

  // Write launched in a cnt==0 cycle so it is stored well before the next wrap.
  task automatic write_aligned(input int ch, input int target, input int step);
    int w;
    w = 0;
    while (!period_start && w < 30) begin
      @(negedge clk);
      w++;
    end
    wif.wr_en = 1'b1; wif.wr_ch = 2'(ch); wif.wr_target = 4'(target); wif.wr_step = 4'(step);
    @(negedge clk);
    wif.wr_en = 1'b0;
    $display("write ch=%0d target=%0d step=%0d", ch, target, step);
  endtask

  task automatic test_reset();
    int n;
    if (pwm_out !== 3'b000) begin errors++; $display("FAIL rst_pwm: got %b required 000", pwm_out); end
    if (settled !== 3'b111) begin errors++; $display("FAIL rst_settled: got %b required 111", settled); end
    if (period_start !== 1'b0) begin errors++; $display("FAIL rst_ps: got %b required 0", period_start); end
    checks += 3;
    @(negedge clk); rst_n = 1'b1;
    write_aligned(0, 10, 0);
    measure("pre_reset");
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    if (pwm_out !== 3'b000) begin errors++; $display("FAIL midrst_pwm: got %b required 000", pwm_out); end
    if (settled !== 3'b111) begin errors++; $display("FAIL midrst_settled: got %b required 111", settled); end
    if (period_start !== 1'b0) begin errors++; $display("FAIL midrst_ps: got %b required 0", period_start); end
    checks += 3;
    @(negedge clk); rst_n = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!period_start && n < 30);
    checks++;
    if (n != 10) begin errors++; $display("FAIL rst_first_ps: got %0d clks required 10", n); end
    measure("post_reset");
    checks += 2;
    if (hi_cnt[0] != 0) begin errors++; $display("FAIL rst_duty0: got %0d required 0", hi_cnt[0]); end
    if (set_s !== 3'b111) begin errors++; $display("FAIL rst_settled_after: got %b required 111", set_s); end
  endtask

  task automatic test_jump();
    write_aligned(0, 4, 0);
    measure("jump");
    checks += 2;
    if (hi_cnt[0] != 4) begin errors++; $display("FAIL jump_duty: got %0d required 4", hi_cnt[0]); end
    if (set_s[0] !== 1'b1) begin errors++; $display("FAIL jump_settled: got %b required 1", set_s[0]); end
    @(negedge clk);
    checks++;
    if (period_start !== 1'b0) begin errors++; $display("FAIL ps_width: got %b required 0", period_start); end
  endtask

  task automatic test_fade_up();
    int exp_d [4] = '{3, 6, 9, 10};
    write_aligned(1, 10, 3);
    for (int p = 0; p < 4; p++) begin
      measure("fade_up");
      checks += 2;
      if (hi_cnt[1] != exp_d[p]) begin errors++; $display("FAIL fade_up_duty p%0d: got %0d required %0d", p, hi_cnt[1], exp_d[p]); end
      if (set_s[1] !== (p == 3)) begin errors++; $display("FAIL fade_up_settled p%0d: got %b required %b", p, set_s[1], (p == 3)); end
    end
    measure("full_on");
    checks += 2;
    if (hi_cnt[1] != 10) begin errors++; $display("FAIL full_duty: got %0d required 10", hi_cnt[1]); end
    if (first_s[1] !== 1'b1) begin errors++; $display("FAIL full_no_dip: got %b required 1", first_s[1]); end
  endtask

  task automatic test_fade_down();
    int exp_d [4] = '{6, 2, 1, 1};
    write_aligned(2, 15, 0);
    measure("clamp");
    checks++;
    if (hi_cnt[2] != 10) begin errors++; $display("FAIL clamp_duty: got %0d required 10", hi_cnt[2]); end
    write_aligned(2, 1, 4);
    for (int p = 0; p < 4; p++) begin
      measure("fade_down");
      checks += 2;
      if (hi_cnt[2] != exp_d[p]) begin errors++; $display("FAIL fade_down_duty p%0d: got %0d required %0d", p, hi_cnt[2], exp_d[p]); end
      if (set_s[2] !== (p >= 2)) begin errors++; $display("FAIL fade_down_settled p%0d: got %b required %b", p, set_s[2], (p >= 2)); end
    end
  endtask

  task automatic test_collision();
    int w;
    w = 0;
    while (!period_start && w < 30) begin
      @(negedge clk);
      w++;
    end
    repeat (9) @(negedge clk);
    wif.wr_en = 1'b1; wif.wr_ch = 2'd0; wif.wr_target = 4'd7; wif.wr_step = 4'd0;
    @(negedge clk);
    wif.wr_en = 1'b0;
    $display("write ch=0 target=7 step=0 on wrap edge");
    measure("collide_1");
    checks += 2;
    if (hi_cnt[0] != 4) begin errors++; $display("FAIL collide_old: got %0d required 4", hi_cnt[0]); end
    if (set_s[0] !== 1'b0) begin errors++; $display("FAIL collide_settled: got %b required 0", set_s[0]); end
    measure("collide_2");
    checks++;
    if (hi_cnt[0] != 7) begin errors++; $display("FAIL collide_new: got %0d required 7", hi_cnt[0]); end
  endtask

  task automatic test_bad_index();
    int ones;
    int unset;
    write_aligned(3, 2, 0);
    measure("bad_index");
    checks += 4;
    if (hi_cnt[0] != 7) begin errors++; $display("FAIL bad_ch0: got %0d required 7", hi_cnt[0]); end
    if (hi_cnt[1] != 10) begin errors++; $display("FAIL bad_ch1: got %0d required 10", hi_cnt[1]); end
    if (hi_cnt[2] != 1) begin errors++; $display("FAIL bad_ch2: got %0d required 1", hi_cnt[2]); end
    if (set_s !== 3'b111) begin errors++; $display("FAIL bad_settled: got %b required 111", set_s); end

    @(negedge clk);
    wif1.wr_en = 1'b1; wif1.wr_ch = 1'b1; wif1.wr_target = 4'd5; wif1.wr_step = 4'd0;
    @(negedge clk);
    wif1.wr_en = 1'b0;
    $display("single-channel write ch=1 target=5");
    ones = 0; unset = 0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      ones  += int'(pwm_out1[0]);
      unset += int'(!settled1[0]);
    end
    checks += 2;
    if (ones != 0) begin errors++; $display("FAIL one_ch_bad_pwm: got %0d high required 0", ones); end
    if (unset != 0) begin errors++; $display("FAIL one_ch_bad_settled: got %0d unsettled required 0", unset); end

    wif1.wr_en = 1'b1; wif1.wr_ch = 1'b0; wif1.wr_target = 4'd5; wif1.wr_step = 4'd0;
    @(negedge clk);
    wif1.wr_en = 1'b0;
    $display("single-channel write ch=0 target=5");
    repeat (20) @(negedge clk);
    ones = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      ones += int'(pwm_out1[0]);
    end
    checks += 2;
    if (ones != 5) begin errors++; $display("FAIL one_ch_good: got %0d high required 5", ones); end
    if (settled1[0] !== 1'b1) begin errors++; $display("FAIL one_ch_settled: got %b required 1", settled1[0]); end
  endtask

  initial begin
    wif.wr_en = 1'b0; wif.wr_ch = '0; wif.wr_target = '0; wif.wr_step = '0;
    wif1.wr_en = 1'b0; wif1.wr_ch = '0; wif1.wr_target = '0; wif1.wr_step = '0;
    repeat (3) @(negedge clk);
    test_reset();
    test_jump();
    test_fade_up();
    test_fade_down();
    test_collision();
    test_bad_index();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
